// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared state encoding and counter sizing helpers for dac_writer
package dac_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_WAIT   = 3'd4
  } state_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dac_fifo.sv
// rtl/dac_fifo.sv - small synchronous FIFO that drops pushes while full
module dac_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  push_ok, pop_ok;

  // full comes from the pre-edge count, so a push alongside a pop while full is lost
  assign full_o  = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/dac_writer.sv
// rtl/dac_writer.sv - paced parallel D/A writer fed from a sample FIFO
module dac_writer
  import dac_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter int SETUP      = 1,
  parameter int PULSE      = 2,
  parameter int PERIOD     = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_underrun,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             written,
  output logic             underrun,
  output logic [WIDTH-1:0] da_data,
  output logic             da_csb,
  output logic             da_wrb
);

  localparam int PW = cnt_w(PERIOD - 1);
  localparam int HW = cnt_w(max2(SETUP, PULSE) - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    pace_q, pace_d;
  logic [HW-1:0]    ph_q, ph_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             csb_q, csb_d;
  logic             wrb_q, wrb_d;
  logic             written_q, written_d;
  logic             underrun_q, underrun_d;
  logic             pop;
  logic [WIDTH-1:0] head;

  dac_fifo #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .resetb  (resetb),
    .push_i  (load),
    .din_i   (din),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d    = state_q;
    pace_d     = (state_q != S_IDLE && pace_q != '0) ? pace_q - 1'b1 : pace_q;
    ph_d       = ph_q;
    data_d     = data_q;
    csb_d      = csb_q;
    wrb_d      = wrb_q;
    written_d  = 1'b0;
    underrun_d = underrun_q & ~clr_underrun;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        csb_d = 1'b1;
        wrb_d = 1'b1;
      end
      S_SETUP: begin
        if (ph_q == '0) begin
          wrb_d   = 1'b0;
          ph_d    = HW'(PULSE - 1);
          state_d = S_STROBE;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (ph_q == '0) begin
          wrb_d     = 1'b1;
          written_d = 1'b1;
          state_d   = S_HOLD;
        end else begin
          ph_d = ph_q - 1'b1;
        end
      end
      S_HOLD: begin
        csb_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (pace_q == '0 && empty) begin
          underrun_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a new write starts from idle, or from wait once the pacing period has elapsed
    if (!empty && (state_q == S_IDLE || (state_q == S_WAIT && pace_q == '0))) begin
      pop     = 1'b1;
      data_d  = head;
      csb_d   = 1'b0;
      wrb_d   = 1'b1;
      pace_d  = PW'(PERIOD - 1);
      ph_d    = HW'(SETUP - 1);
      state_d = S_SETUP;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= S_IDLE;
      pace_q     <= '0;
      ph_q       <= '0;
      data_q     <= '0;
      csb_q      <= 1'b1;
      wrb_q      <= 1'b1;
      written_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pace_q     <= pace_d;
      ph_q       <= ph_d;
      data_q     <= data_d;
      csb_q      <= csb_d;
      wrb_q      <= wrb_d;
      written_q  <= written_d;
      underrun_q <= underrun_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign written  = written_q;
  assign underrun = underrun_q;
  assign da_data  = data_q;
  assign da_csb   = csb_q;
  assign da_wrb   = wrb_q;

endmodule

// File: tb/tb_dac_writer.sv
// tb/tb_dac_writer.sv - self-checking bench for dac_writer against a timeline model
module tb_dac_writer;

  localparam int WIDTH      = 8;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int SETUP      = 1;
  localparam int PULSE      = 2;
  localparam int PERIOD     = 16;

  logic             clk = 1'b0;
  logic             resetb = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             clr_underrun = 1'b0;
  logic             full, empty, busy, written, underrun;
  logic [WIDTH-1:0] da_data;
  logic             da_csb, da_wrb;

  dac_writer #(
    .WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2), .SETUP(SETUP), .PULSE(PULSE), .PERIOD(PERIOD)
  ) dut (
    .clk          (clk),
    .resetb       (resetb),
    .load         (load),
    .din          (din),
    .clr_underrun (clr_underrun),
    .full         (full),
    .empty        (empty),
    .busy         (busy),
    .written      (written),
    .underrun     (underrun),
    .da_data      (da_data),
    .da_csb       (da_csb),
    .da_wrb       (da_wrb)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int nfail = 0;
  int ntotal = 0;

  // Model: a write that starts on edge s is described purely by the offset d = n - s
  logic [WIDTH-1:0] mq[$];
  bit               m_act;
  int               m_s;
  int               m_n;
  logic [WIDTH-1:0] m_data;
  bit               m_und;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_act  = 0;
    m_s    = 0;
    m_n    = 0;
    m_data = '0;
    m_und  = 0;
  endtask

  task automatic model_step(input logic ld, input logic [WIDTH-1:0] d, input logic clr);
    bit full_pre;
    bit ev;
    int off;
    m_n++;
    full_pre = (mq.size() == DEPTH);
    off      = m_n - m_s;
    ev       = 0;
    if (mq.size() > 0 && (!m_act || off == PERIOD)) begin
      m_data = mq.pop_front();
      m_s    = m_n;
      m_act  = 1;
    end else if (m_act && off == PERIOD) begin
      m_act = 0;
      ev    = 1;
    end
    if (ev) m_und = 1;
    else if (clr) m_und = 0;
    if (ld && !full_pre) mq.push_back(d);
  endtask

  task automatic compare_all();
    int  off;
    bit  e_csb, e_wrb, e_wr;
    off   = m_n - m_s;
    e_csb = !(m_act && off <= SETUP + PULSE);
    e_wrb = !(m_act && off >= SETUP && off < SETUP + PULSE);
    e_wr  = m_act && off == SETUP + PULSE;
    chk("da_csb",   da_csb,   e_csb);
    chk("da_wrb",   da_wrb,   e_wrb);
    chk("written",  written,  e_wr);
    chk("busy",     busy,     m_act);
    chk("da_data",  da_data,  m_data);
    chk("empty",    empty,    mq.size() == 0);
    chk("full",     full,     mq.size() == DEPTH);
    chk("underrun", underrun, m_und);
  endtask

  task automatic tick(input logic ld, input logic [WIDTH-1:0] d, input logic clr);
    load = ld;
    din = d;
    clr_underrun = clr;
    @(posedge clk);
    model_step(ld, d, clr);
    #1;
    compare_all();
    load = 1'b0;
    clr_underrun = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0);
  endtask

  bit seen77;

  initial begin
    model_reset();
    resetb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csb", da_csb, 1'b1);
    chk("rst_wrb", da_wrb, 1'b1);
    chk("rst_data", da_data, 8'h00);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_written", written, 1'b0);
    resetb = 1'b1;

    // single word A5 loaded at E0
    tick(1'b1, 8'hA5, 1'b0);
    run(1);
    chk("a5_csb_E1", da_csb, 1'b0);
    run(1);
    chk("a5_wrb_E2", da_wrb, 1'b0);
    run(2);
    chk("a5_written_E4", written, 1'b1);
    chk("a5_wrb_E4", da_wrb, 1'b1);
    chk("a5_data", da_data, 8'hA5);
    run(12);
    chk("a5_und_E16", underrun, 1'b0);
    run(1);
    chk("a5_und_E17", underrun, 1'b1);
    chk("a5_busy_E17", busy, 1'b0);
    tick(1'b0, '0, 1'b1);
    chk("clr_alone", underrun, 1'b0);

    // burst 01..05 then 06 while full
    for (int i = 1; i <= 5; i++) tick(1'b1, WIDTH'(i), 1'b0);
    chk("burst_full_E4", full, 1'b1);
    tick(1'b1, 8'h06, 1'b0);
    run(75);
    chk("burst_und_E80", underrun, 1'b0);
    tick(1'b0, '0, 1'b1);
    chk("burst_set_wins_E81", underrun, 1'b1);
    tick(1'b0, '0, 1'b1);
    chk("burst_clr", underrun, 1'b0);

    // full FIFO, pacing expires with a coincident load of 77
    for (int i = 1; i <= 5; i++) tick(1'b1, WIDTH'(i * 17), 1'b0);
    run(12);
    chk("fp_full_E16", full, 1'b1);
    tick(1'b1, 8'h77, 1'b0);
    chk("fp_full_E17", full, 1'b0);
    chk("fp_data_E17", da_data, 8'h22);
    seen77 = 0;
    for (int i = 0; i < 70; i++) begin
      tick(1'b0, '0, 1'b0);
      if (da_data === 8'h77) seen77 = 1;
    end
    chk("fp_no77", seen77, 1'b0);
    tick(1'b0, '0, 1'b1);

    // asynchronous reset while the strobe is low
    tick(1'b1, 8'h3C, 1'b0);
    tick(1'b1, 8'h4D, 1'b0);
    run(1);
    chk("mr_wrb_low", da_wrb, 1'b0);
    #2;
    resetb = 1'b0;
    #1;
    chk("mr_csb_async", da_csb, 1'b1);
    chk("mr_wrb_async", da_wrb, 1'b1);
    chk("mr_written", written, 1'b0);
    chk("mr_busy", busy, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    resetb = 1'b1;
    chk("mr_empty", empty, 1'b1);
    run(6);

    // random traffic: heavy phase exercises drops, light phase exercises underruns
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 9) < 3, WIDTH'($urandom), $urandom_range(0, 19) == 0);
    for (int i = 0; i < 600; i++)
      tick($urandom_range(0, 24) == 0, WIDTH'($urandom), $urandom_range(0, 14) == 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
